pc_unit_gen2: RTL and testbench
===============================

Name: pc_unit_gen2

Overview:
Parametrised program-counter unit for the MIPS fetch stage. It replaces the fixed 32-bit single-branch PC. It holds the PC register and selects the next PC from these sources:
- sequential increment
- PC-relative branch
- absolute jump
- register jump
- a hardware return-address stack (RAS) for call/return
It drives the instruction-memory address and supplies the link address to the register file.

Parameters:
PC_W, 32, PC width in bits (>= JMP_W+4).
IMM_W, 16, branch immediate width; sign-extended to PC_W.
JMP_W, 26, jump target field width.
RESET_VEC, 0, PC value loaded on reset.
RAS_DEPTH, 4, return-address stack entries (power of 2, >= 2).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
stall  input  1  hold PC and RAS; all redirects ignored this cycle.
branch_taken  input  1  conditional branch resolved taken.
imm  input  IMM_W  branch word offset.
jump_en  input  1  absolute jump (j/jal).
jump_target  input  JMP_W  jump word target field.
jr_en  input  1  register jump (jr/jalr).
jr_addr  input  PC_W  register jump target.
call  input  1  qualifies jump_en/jr_en as a link instruction: push link address.
ret  input  1  qualifies jr_en as a return: pop RAS, use its top as target.
pc_out  output  PC_W  current PC.
pc_plus4  output  PC_W  pc_out+4, combinational.
link_addr  output  PC_W  return address for call (pc+4; pc+8 with delay slot).
ras_empty  output  1  RAS holds no entries.
ras_full  output  1  RAS holds RAS_DEPTH entries.
ras_ovf  output  1  sticky: push while full occurred.
ras_unf  output  1  sticky: ret while empty occurred.
addr_err  output  1  one-cycle pulse: selected register target had addr[1:0]!=0.

Behaviour:
- Reset (asynchronous, any time, including mid-redirect):
  - pc_out=RESET_VEC; RAS count=0 and pointer=0.
  - ras_ovf, ras_unf, addr_err = 0; any pending delay-slot redirect is cleared.
  - Stack entry contents are don't-care.
- Next-PC priority, evaluated each non-stalled cycle (first match wins):
  1. jr_en & ret & !ras_empty -> RAS top.
  2. jr_en -> jr_addr.
  3. jump_en -> {pc_plus4[PC_W-1:JMP_W+2], jump_target, 2'b00}.
  4. branch_taken -> pc_plus4 + (sext(imm)<<2), modulo 2^PC_W.
  5. Otherwise -> pc_plus4.
- Arithmetic:
  - All adds wrap modulo 2^PC_W; no overflow flag.
  - PC at 2^PC_W-4 increments to 0.
- Register targets (cases 1 and 2):
  - bits[1:0] are forced to 00.
  - addr_err pulses in the same cycle the PC updates, only if the raw target was misaligned.
- Latency: one clock from a redirect input to pc_out showing the target (no delay slot).
- stall=1: pc_out, RAS and the sticky flags hold; addr_err=0.
- RAS push (call & (jump_en | jr_en), not stalled):
  - Writes link_addr at pointer+1.
  - When not full, count increments.
  - When full, the oldest entry is overwritten (circular), count stays at RAS_DEPTH, and ras_ovf is set.
- RAS pop (jr_en & ret, not stalled):
  - When not empty, count decrements.
  - When empty, nothing is popped, the target falls back to jr_addr, and ras_unf is set.
- call & ret together with jr_en: the pop is taken as the target, then link_addr replaces the top (net count unchanged; count 0 -> becomes 1).
- call or ret without jump_en/jr_en: ignored.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH); both registered outputs.

Optional Feature:
Macro BRANCH_DELAY_SLOT_EN.
- Defined:
  - A redirect loads the target into a pending register, and the next PC is pc_plus4 (delay slot).
  - On the next non-stalled cycle the PC takes the pending target.
  - Redirect inputs arriving in the delay-slot cycle are ignored.
  - link_addr = pc_out+8.
  - Stall during the slot keeps the pending target.
  - Reset clears the pending target.
- Undefined: immediate redirect with one-cycle latency; link_addr = pc_out+4; no pending register.

Test Plan:
- Reset asserted mid-cycle, RESET_VEC=0, then 3 free-running clocks -> pc_out 0 immediately, then 4, 8, 12.
- pc=104, branch_taken=1, imm=100 -> next pc_out=508; with imm=16'hFFFF -> next pc_out=104.
- Two cycles with stall=1 while jump_en=1 -> pc_out and ras_empty unchanged; after stall drops, the jump is taken on the next edge.
- jump_en&call at pc=0x40, jump_target=0x100 -> pc_out=0x400, ras_empty=0; then jr_en&ret -> pc_out=0x44.
- Five jal calls with RAS_DEPTH=4 -> ras_full=1, ras_ovf=1; five returns -> first four pop newest-first, the fifth uses jr_addr and sets ras_unf=1.
- jr_en with jr_addr=0x203 -> pc_out=0x200 and an addr_err pulse. With BRANCH_DELAY_SLOT_EN, a branch at pc=104, imm=100 -> pc 108, then 508.

Source files
------------

// File: rtl/pc_unit_gen2.sv
// MIPS fetch program counter: sequential / branch / jump / register jump / return-address stack.
// Optional BRANCH_DELAY_SLOT_EN: redirects take effect after one delay-slot instruction.
module pc_unit_gen2 #(
  parameter int              PC_W      = 32,
  parameter int              IMM_W     = 16,
  parameter int              JMP_W     = 26,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [IMM_W-1:0] imm,
  input  logic             jump_en,
  input  logic [JMP_W-1:0] jump_target,
  input  logic             jr_en,
  input  logic [PC_W-1:0]  jr_addr,
  input  logic             call,
  input  logic             ret,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  pc_plus4,
  output logic [PC_W-1:0]  link_addr,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf,
  output logic             addr_err
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr, ptr_nxt, wr_idx;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             wr_en, set_ovf, set_unf;

  logic [PC_W-1:0]  imm_sext, branch_tgt, jump_tgt, reg_raw, target, pc_nxt;
  logic             redirect, accept, is_call, is_ret, pop_ok, push, pop;

  assign pc_out   = pc;
  assign pc_plus4 = pc + PC_W'(4);

  assign imm_sext   = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign branch_tgt = pc_plus4 + (imm_sext << 2);
  assign jump_tgt   = {pc_plus4[PC_W-1:JMP_W+2], jump_target, 2'b00};

  assign is_call = call & (jump_en | jr_en);
  assign is_ret  = jr_en & ret;
  assign pop_ok  = is_ret & (cnt != '0);
  // The RAS top replaces jr_addr only when something can actually be popped.
  assign reg_raw = pop_ok ? ras_mem[ptr] : jr_addr;

  always_comb begin
    target = pc_plus4;
    if (jr_en)             target = {reg_raw[PC_W-1:2], 2'b00};
    else if (jump_en)      target = jump_tgt;
    else if (branch_taken) target = branch_tgt;
  end
  assign redirect = jr_en | jump_en | branch_taken;

`ifdef BRANCH_DELAY_SLOT_EN
  logic            pend_vld;
  logic [PC_W-1:0] pend_pc;

  // While a target is pending, the slot instruction's redirect inputs are dropped.
  assign accept    = !stall && !pend_vld;
  assign pc_nxt    = pend_vld ? pend_pc : pc_plus4;
  assign link_addr = pc + PC_W'(8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend_pc  <= '0;
    end else if (!stall) begin
      if (pend_vld) begin
        pend_vld <= 1'b0;
      end else if (redirect) begin
        pend_vld <= 1'b1;
        pend_pc  <= target;
      end
    end
  end
`else
  assign accept    = !stall;
  assign pc_nxt    = target;
  assign link_addr = pc_plus4;
`endif

  assign push = accept & is_call;
  assign pop  = accept & pop_ok;

  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    wr_en   = 1'b0;
    wr_idx  = ptr + PTR_W'(1);
    set_ovf = 1'b0;
    set_unf = accept & is_ret & (cnt == '0);
    if (push && pop) begin
      // call+return: consume the top as target, then overwrite it with the new link.
      wr_en  = 1'b1;
      wr_idx = ptr;
    end else if (push) begin
      wr_en   = 1'b1;
      ptr_nxt = ptr + PTR_W'(1);
      if (cnt == CNT_FULL) set_ovf = 1'b1;
      else                 cnt_nxt = cnt + CNT_W'(1);
    end else if (pop) begin
      ptr_nxt = ptr - PTR_W'(1);
      cnt_nxt = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ras_mem[wr_idx] <= link_addr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= RESET_VEC;
      ptr       <= '0;
      cnt       <= '0;
      ras_empty <= 1'b1;
      ras_full  <= 1'b0;
      ras_ovf   <= 1'b0;
      ras_unf   <= 1'b0;
    end else if (!stall) begin
      pc        <= pc_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      ras_empty <= (cnt_nxt == '0);
      ras_full  <= (cnt_nxt == CNT_FULL);
      ras_ovf   <= ras_ovf | set_ovf;
      ras_unf   <= ras_unf | set_unf;
    end
  end

  // Flags the register target chosen in this cycle, i.e. the one the coming edge uses.
  assign addr_err = !reset & accept & jr_en & (reg_raw[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_unit_gen2.sv
// Directed table-driven bench for pc_unit_gen2 (default parameters).
module tb_pc_unit_gen2;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump_en, jr_en, call, ret;
  logic [15:0] imm;
  logic [25:0] jump_target;
  logic [31:0] jr_addr;
  logic [31:0] pc_out, pc_plus4, link_addr;
  logic        ras_empty, ras_full, ras_ovf, ras_unf, addr_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_unit_gen2 dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken), .imm(imm),
    .jump_en(jump_en), .jump_target(jump_target), .jr_en(jr_en), .jr_addr(jr_addr),
    .call(call), .ret(ret), .pc_out(pc_out), .pc_plus4(pc_plus4), .link_addr(link_addr),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf),
    .addr_err(addr_err)
  );

  typedef struct {
    logic        stall, br, jmp, jr, call, ret;
    logic [15:0] imm;
    logic [25:0] jt;
    logic [31:0] jra;
    logic [31:0] e_pc;
    logic        e_empty, e_full, e_ovf, e_unf, e_aerr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, br, jmp, jr, cl, rt, input logic [15:0] im,
                       input logic [25:0] jt, input logic [31:0] jra);
    stall = st; branch_taken = br; jump_en = jmp; jr_en = jr; call = cl; ret = rt;
    imm = im; jump_target = jt; jr_addr = jra;
  endtask

  function automatic vec_t mk(input logic st, br, jmp, jr, cl, rt, input logic [15:0] im,
                              input logic [25:0] jt, input logic [31:0] jra, input logic [31:0] pc,
                              input logic emp, ful, ovf, unf, aerr);
    vec_t v;
    v.stall = st; v.br = br; v.jmp = jmp; v.jr = jr; v.call = cl; v.ret = rt;
    v.imm = im; v.jt = jt; v.jra = jra; v.e_pc = pc;
    v.e_empty = emp; v.e_full = ful; v.e_ovf = ovf; v.e_unf = unf; v.e_aerr = aerr;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0, '0, '0);
    #1;
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_empty", {31'b0, ras_empty}, 32'd1);
    chk("reset_flags", {28'b0, ras_full, ras_ovf, ras_unf, addr_err}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("run_pc", pc_out, 32'h8);
    // Async reset applied mid-cycle must take effect without a clock edge.
    #2 reset = 1'b1;
    #1 chk("async_reset_pc", pc_out, 32'h0);
    @(negedge clk); reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      chk("free_run_pc", pc_out, 32'(4 * i));
    end

`ifdef BRANCH_DELAY_SLOT_EN
    // pc=12: jump to 104 goes through the slot at 16.
    @(negedge clk); drive(0, 0, 1, 0, 0, 0, '0, 26'd26, '0);
    chk("ds_link", link_addr, 32'd20);
    @(posedge clk); #1 chk("ds_slot_pc", pc_out, 32'd16);
    @(negedge clk); drive(0, 1, 0, 0, 0, 0, 16'd4, '0, '0);
    @(posedge clk); #1 chk("ds_target_pc", pc_out, 32'd104);
    @(negedge clk); drive(0, 1, 0, 0, 0, 0, 16'd100, '0, '0);
    @(posedge clk); #1 chk("ds_branch_slot", pc_out, 32'd108);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, '0, '0, '0);
    @(posedge clk); #1 chk("ds_branch_tgt", pc_out, 32'd508);
`else
    //            st br jmp jr cl rt imm        jt        jra            pc            emp ful ovf unf aerr
    tbl.push_back(mk(0,0,1,0,0,0, 16'd0,     26'd26,   32'h0,         32'd104,      1,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 16'd100,   26'd0,    32'h0,         32'd508,      1,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 16'd0,     26'd26,   32'h0,         32'd104,      1,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 16'hFFFF,  26'd0,    32'h0,         32'd104,      1,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,1,0, 16'd0,     26'h10,   32'h0,         32'd104,      1,0,0,0,0));
    tbl.push_back(mk(1,0,0,1,0,0, 16'd0,     26'h10,   32'h3,         32'd104,      1,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,0,0, 16'd0,     26'h10,   32'h0,         32'h40,       1,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0, 16'd0,     26'h100,  32'h0,         32'h400,      0,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,1, 16'd0,     26'h0,    32'h999,       32'h44,       1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,0,0, 16'd0,     26'h0,    32'h203,       32'h200,      1,0,0,0,1));
    // five calls into a 4-deep stack: links 204,404,804,C04,1004
    tbl.push_back(mk(0,0,1,0,1,0, 16'd0,     26'h100,  32'h0,         32'h400,      0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0, 16'd0,     26'h200,  32'h0,         32'h800,      0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0, 16'd0,     26'h300,  32'h0,         32'hC00,      0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0, 16'd0,     26'h400,  32'h0,         32'h1000,     0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,1,0, 16'd0,     26'h500,  32'h0,         32'h1400,     0,1,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,1, 16'd0,     26'h0,    32'h7,         32'h1004,     0,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,1, 16'd0,     26'h0,    32'h7,         32'hC04,      0,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,1, 16'd0,     26'h0,    32'h7,         32'h804,      0,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,1, 16'd0,     26'h0,    32'h7,         32'h404,      1,0,1,0,0));
    tbl.push_back(mk(0,0,0,1,0,1, 16'd0,     26'h0,    32'h3000,      32'h3000,     1,0,1,1,0));
    // call+ret on empty stack: fallback target, link 3004 pushed
    tbl.push_back(mk(0,0,0,1,1,1, 16'd0,     26'h0,    32'h500,       32'h500,      0,0,1,1,0));
    tbl.push_back(mk(0,0,0,1,0,1, 16'd0,     26'h0,    32'h0,         32'h3004,     1,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,1,1, 16'd0,     26'h0,    32'h0,         32'h3008,     1,0,1,1,0));
    tbl.push_back(mk(0,0,0,1,0,0, 16'd0,     26'h0,    32'hFFFFFFFE,  32'hFFFFFFFC, 1,0,1,1,1));
    tbl.push_back(mk(0,0,0,0,0,0, 16'd0,     26'h0,    32'h0,         32'h0,        1,0,1,1,0));

    foreach (tbl[i]) begin
      logic [31:0] prev_pc;
      @(negedge clk);
      prev_pc = pc_out;
      drive(tbl[i].stall, tbl[i].br, tbl[i].jmp, tbl[i].jr, tbl[i].call, tbl[i].ret,
            tbl[i].imm, tbl[i].jt, tbl[i].jra);
      #1;
      chk($sformatf("v%0d_addr_err", i), {31'b0, addr_err}, {31'b0, tbl[i].e_aerr});
      chk($sformatf("v%0d_link", i), link_addr, prev_pc + 32'd4);
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i), pc_out, tbl[i].e_pc);
      chk($sformatf("v%0d_pc_plus4", i), pc_plus4, tbl[i].e_pc + 32'd4);
      chk($sformatf("v%0d_flags", i), {28'b0, ras_empty, ras_full, ras_ovf, ras_unf},
          {28'b0, tbl[i].e_empty, tbl[i].e_full, tbl[i].e_ovf, tbl[i].e_unf});
    end

    // Reset clears the sticky flags and the stack.
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, '0, '0, '0);
    reset = 1'b1;
    #1 chk("reset2_flags", {28'b0, ras_empty, ras_full, ras_ovf, ras_unf}, 32'b1000);
    @(negedge clk); reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
